// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-ROM request/response bus; the fetch unit is master, the ROM is slave.
interface fetch_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             rom_req;
  logic [WIDTH-1:0] rom_address;
  logic             rom_ready;
  logic             rom_valid;
  logic [WIDTH-1:0] rom_data;

  modport master (
    output rom_req,
    output rom_address,
    input  rom_ready,
    input  rom_valid,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_address,
    output rom_ready,
    output rom_valid,
    output rom_data
  );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry shift-register FIFO of fetch entries; entry 0 is the registered head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  entries_r [DEPTH];
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          valid_r;
  logic          pop_s;
  logic          push_s;
  logic [AW-1:0] wr_idx_s;

  // Qualify pop/push against occupancy and compute the next count.
  always_comb begin
    pop_s    = pop & (count_r != {CW{1'b0}});
    push_s   = push & ((count_r != CW'(DEPTH)) | pop_s);
    wr_idx_s = AW'(count_r - CW'(pop_s));
    if (clear) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Storage, count and head-valid registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      count_r <= {CW{1'b0}};
      valid_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CW{1'b0}});
      if (!clear) begin
        if (pop_s) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            entries_r[i] <= entries_r[i+1];
          end
        end
        // Later assignment wins, so a push lands after the shift.
        if (push_s) begin
          entries_r[wr_idx_s] <= push_entry;
        end
      end
    end
  end

  assign head  = entries_r[0];
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC generator, credit-limited ROM requests, prefetch queue.
// Optional macro FETCH_BYPASS_EN: zero-latency bypass of a kept response into an empty queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [WIDTH-1:0]  redirect_pc,
  input  logic              dec_ready,
  fetch_unit_if.master      rom,
  output logic              inst_valid,
  output logic [WIDTH-1:0]  instruction,
  output logic [WIDTH-1:0]  inst_pc,
  output logic [WIDTH-1:0]  inst_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_r;
  fetch_state_t  state_next_s;
  logic [WIDTH-1:0] fetch_pc_r;
  logic [WIDTH-1:0] resp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;
  logic [CW-1:0] discard_next_s;
  logic [CW-1:0] q_count_s;
  logic [CW:0]   credit_used_s;
  logic          req_en_s;
  logic          accept_s;
  logic          keep_s;
  logic          push_s;
  logic          pop_s;
  logic          q_valid_s;
  fetch_entry_t  q_head_s;
  fetch_entry_t  push_entry_s;
`ifdef FETCH_BYPASS_EN
  logic          bypass_s;
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    case (state_r)
      IDLE:       state_next_s = RUN;
      RUN, DRAIN: state_next_s = (discard_next_s != {CW{1'b0}}) ? DRAIN : RUN;
      default:    state_next_s = IDLE;
    endcase
  end

  // FSM output logic.
  always_comb begin
    case (state_r)
      RUN, DRAIN: req_en_s = 1'b1;
      default:    req_en_s = 1'b0;
    endcase
  end

  // Credit check, request/accept and response classification.
  always_comb begin
    credit_used_s   = {1'b0, q_count_s} + {1'b0, outstanding_r};
    rom.rom_req     = req_en_s & ~redirect & (credit_used_s < (CW+1)'(DEPTH));
    rom.rom_address = fetch_pc_r;
    accept_s        = rom.rom_req & rom.rom_ready;
    keep_s          = rom.rom_valid & (discard_r == {CW{1'b0}}) & ~redirect;
    // outstanding already includes responses awaiting discard, so all in-flight become stale.
    if (redirect) begin
      discard_next_s = outstanding_r - CW'(rom.rom_valid);
    end else if (rom.rom_valid && (discard_r != {CW{1'b0}})) begin
      discard_next_s = discard_r - CW'(1'b1);
    end else begin
      discard_next_s = discard_r;
    end
  end

  // PC, in-flight and discard registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
    end else begin
      outstanding_r <= outstanding_r + CW'(accept_s) - CW'(rom.rom_valid);
      discard_r     <= discard_next_s;
      if (redirect) begin
        fetch_pc_r <= redirect_pc;
        resp_pc_r  <= redirect_pc;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + WIDTH'(INSTR_BYTES);
        end
        if (keep_s) begin
          resp_pc_r <= resp_pc_r + WIDTH'(INSTR_BYTES);
        end
      end
    end
  end

  // Queue control and decode-facing outputs.
  always_comb begin
    push_entry_s = '{pc: resp_pc_r, instr: rom.rom_data};
    pop_s        = dec_ready & ~redirect;
`ifdef FETCH_BYPASS_EN
    bypass_s = keep_s & (q_count_s == {CW{1'b0}});
    push_s   = keep_s & ~(bypass_s & dec_ready);
    if (bypass_s) begin
      inst_valid  = 1'b1;
      instruction = rom.rom_data;
      inst_pc     = resp_pc_r;
    end else begin
      inst_valid  = q_valid_s;
      instruction = q_head_s.instr;
      inst_pc     = q_head_s.pc;
    end
`else
    push_s      = keep_s;
    inst_valid  = q_valid_s;
    instruction = q_head_s.instr;
    inst_pc     = q_head_s.pc;
`endif
    if (inst_valid) begin
      inst_pc_plus4 = inst_pc + WIDTH'(INSTR_BYTES);
    end else begin
      inst_pc_plus4 = {WIDTH{1'b0}};
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .clear      (redirect),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (q_head_s),
    .valid      (q_valid_s),
    .count      (q_count_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a variable-latency ROM model plus an abstract
// scoreboard of in-flight requests and queued instruction addresses.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  fetch_unit_if #(.WIDTH(32)) rom_bus ();

  fetch_unit #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .dec_ready     (dec_ready),
    .rom           (rom_bus),
    .inst_valid    (inst_valid),
    .instruction   (instruction),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4)
  );

  always #5 clock = ~clock;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          cyc          = 0;
  pend_t       pend[$];
  logic [31:0] mq[$];
  logic [31:0] next_req_pc;
  logic [31:0] dec_pc;
  int          lat_min, lat_max, ready_pct, dec_pct, redir_permil;
  bit          force_redir;
  logic [31:0] force_tgt;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle; entered just after a falling edge, leaves just after the next one.
  task automatic step();
    bit          do_redir, resp_now, kept_now, byp, exp_req, exp_valid, accept;
    logic [31:0] tgt, vpc;
    pend_t       p;
    tgt = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000C);
    do_redir = force_redir || ((cyc >= 1) && ($urandom_range(999) < redir_permil));
    if (force_redir) tgt = force_tgt;
    redirect          = do_redir;
    redirect_pc       = tgt;
    rom_bus.rom_ready = ($urandom_range(99) < ready_pct);
    dec_ready         = ($urandom_range(99) < dec_pct);
    resp_now          = (pend.size() > 0) && (pend[0].due <= cyc);
    rom_bus.rom_valid = resp_now;
    rom_bus.rom_data  = resp_now ? rom_word(pend[0].addr) : $urandom;
    #1;
    kept_now = resp_now && !pend[0].stale && !do_redir;
    exp_req  = (cyc >= 1) && !do_redir && ((mq.size() + pend.size()) < DEPTH);
    check_value("rom_req", {31'd0, rom_bus.rom_req}, {31'd0, exp_req});
    if (exp_req) check_value("rom_address", rom_bus.rom_address, next_req_pc);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = kept_now && (mq.size() == 0);
`endif
    exp_valid = (mq.size() > 0) || byp;
    check_value("inst_valid", {31'd0, inst_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      vpc = byp ? pend[0].addr : mq[0];
      check_value("inst_pc", inst_pc, vpc);
      check_value("instruction", instruction, rom_word(vpc));
      check_value("inst_pc_plus4", inst_pc_plus4, vpc + 32'd4);
      if (dec_ready && !do_redir) begin
        check_value("dec_order", vpc, dec_pc);
        dec_pc = dec_pc + 32'd4;
      end
    end
    accept = exp_req && rom_bus.rom_ready;
    if (do_redir) begin
      mq.delete();
      if (resp_now) p = pend.pop_front();
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      next_req_pc = tgt;
      dec_pc      = tgt;
    end else begin
      if (exp_valid && dec_ready && !byp) void'(mq.pop_front());
      if (resp_now) begin
        p = pend.pop_front();
        if (!p.stale && !(byp && dec_ready)) mq.push_back(p.addr);
      end
      if (accept) begin
        p.addr  = next_req_pc;
        p.due   = cyc + $urandom_range(lat_max, lat_min);
        p.stale = 1'b0;
        pend.push_back(p);
        next_req_pc = next_req_pc + 32'd4;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int dec, input int rdr);
    lat_min = lmin; lat_max = lmax; ready_pct = rdy; dec_pct = dec; redir_permil = rdr;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset             = 1'b0;
    redirect          = 1'b0;
    rom_bus.rom_valid = 1'b0;
    #1;
    check_value("rst_rom_req", {31'd0, rom_bus.rom_req}, 32'd0);
    check_value("rst_rom_address", rom_bus.rom_address, 32'h0000_0000);
    check_value("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_value("rst_instruction", instruction, 32'd0);
    check_value("rst_inst_pc", inst_pc, 32'd0);
    check_value("rst_inst_pc_plus4", inst_pc_plus4, 32'd0);
    mq.delete();
    pend.delete();
    next_req_pc = 32'h0000_0000;
    dec_pc      = 32'h0000_0000;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; dec_ready = 1'b0;
    rom_bus.rom_ready = 1'b0; rom_bus.rom_valid = 1'b0; rom_bus.rom_data = 32'd0;
    force_redir = 1'b0; force_tgt = 32'd0;
    set_knobs(1, 1, 100, 100, 0);
    @(negedge clock);
    do_reset();

    // Streaming with a 1-cycle ROM, then back-pressure until credits run out.
    repeat (20) step();
    set_knobs(1, 1, 100, 0, 0);
    repeat (15) step();
    set_knobs(1, 1, 100, 100, 0);
    repeat (12) step();

    // Redirect to 0x100 with two responses in flight.
    set_knobs(3, 3, 100, 100, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() == 2) found = 1'b1;
      else step();
    end
    check_value("redir_setup", {31'd0, found}, 32'd1);
    force_redir = 1'b1; force_tgt = 32'h0000_0100;
    step();
    force_redir = 1'b0;
    repeat (15) step();

    // Address wrap past 0xFFFFFFFC.
    set_knobs(1, 1, 100, 100, 0);
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFF8;
    step();
    force_redir = 1'b0;
    repeat (12) step();

    // Random latency, ready, back-pressure and redirects.
    set_knobs(1, 5, 70, 75, 15);
    repeat (1500) step();

    // Fill the queue, then reset mid-stream and restart.
    set_knobs(1, 1, 100, 0, 0);
    repeat (10) step();
    do_reset();
    set_knobs(1, 2, 100, 100, 0);
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
